// File: rtl/sync_frame_pkg.sv
// rtl/sync_frame_pkg.sv - shared types and constants for the 1101 sync-word serializer
package sync_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        PAYLOAD = 2'd2,
        STUFF   = 2'd3
    } state_t;

    localparam logic [3:0] SYNC_WORD     = 4'b1101;
    localparam int         SYNC_LEN      = 4;
    localparam logic [2:0] STUFF_TRIGGER = 3'b110;

    // PAYLOAD and STUFF share the same next-bit decision.
    function automatic logic is_payload_phase(input state_t s);
        return (s == PAYLOAD) || (s == STUFF);
    endfunction

endpackage

// File: rtl/sync_frame_stuff_ctrl.sv
// rtl/sync_frame_stuff_ctrl.sv - last-three-bits history and zero-stuff request
module sync_frame_stuff_ctrl
    import sync_frame_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic drive,
    input  logic line_bit,
    output logic stuff_req
);

    logic [2:0] history;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history <= '0;
        end else if (clr) begin
            history <= '0;
        end else if (drive) begin
            history <= {history[1:0], line_bit};
        end
    end

    // A 1 after "110" would complete a 1101 inside the payload.
    assign stuff_req = (history == STUFF_TRIGGER);

endmodule

// File: rtl/sync_frame_serializer.sv
// rtl/sync_frame_serializer.sv - MSB-first 1101 sync-word framer with zero-bit stuffing
module sync_frame_serializer #(
    parameter int         PAYLOAD_W = 8,
    parameter logic [3:0] SYNC_WORD = sync_frame_pkg::SYNC_WORD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_en,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [PAYLOAD_W-1:0] s_data,
    output logic                 data_out,
    output logic                 tx_active,
    output logic                 frame_done
);
    import sync_frame_pkg::*;

    localparam int CNT_W = $clog2(PAYLOAD_W + 1);

    state_t               state;
    state_t               state_next;
    logic [PAYLOAD_W-1:0] shift_reg;
    logic [1:0]           sync_idx;
    logic [CNT_W-1:0]     pay_cnt;

    logic accept;
    logic step;
    logic in_payload;
    logic last_sync;
    logic do_sync;
    logic do_stuff;
    logic do_pay;
    logic fin;
    logic drive;
    logic stuff_req;

    logic drive_bit;
    logic data_next;
    logic s_ready_next;
    logic tx_active_next;

    assign accept     = s_valid && s_ready;
    assign step       = bit_en && (state != IDLE);
    assign in_payload = is_payload_phase(state);
    assign last_sync  = (sync_idx == 2'(SYNC_LEN - 1));

    assign do_sync  = step && (state == SYNC);
    assign fin      = step && in_payload && (pay_cnt == '0);
    assign do_stuff = step && in_payload && (pay_cnt != '0) && stuff_req;
    assign do_pay   = step && in_payload && (pay_cnt != '0) && !stuff_req;
    assign drive    = do_sync || do_stuff || do_pay;

    sync_frame_stuff_ctrl u_stuff_ctrl (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept),
        .drive     (drive),
        .line_bit  (drive_bit),
        .stuff_req (stuff_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = SYNC;
            end
            SYNC: begin
                if (do_sync && last_sync) state_next = PAYLOAD;
            end
            PAYLOAD, STUFF: begin
                if (fin)           state_next = IDLE;
                else if (do_stuff) state_next = STUFF;
                else if (do_pay)   state_next = PAYLOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        drive_bit = 1'b0;
        if (do_sync) begin
            drive_bit = SYNC_WORD[2'(SYNC_LEN - 1) - sync_idx];
        end else if (do_pay) begin
            drive_bit = shift_reg[PAYLOAD_W-1];
        end

        data_next = data_out;
        if (drive) begin
            data_next = drive_bit;
        end else if (fin) begin
            data_next = 1'b0;
        end

        // s_ready only rises from IDLE, so it lags the frame end by one edge.
        s_ready_next = s_ready;
        if (accept) begin
            s_ready_next = 1'b0;
        end else if (state == IDLE) begin
            s_ready_next = 1'b1;
        end

        tx_active_next = tx_active;
        if (accept) begin
            tx_active_next = 1'b1;
        end else if (fin) begin
            tx_active_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg  <= '0;
            sync_idx   <= '0;
            pay_cnt    <= '0;
            data_out   <= 1'b0;
            s_ready    <= 1'b0;
            tx_active  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            data_out   <= data_next;
            s_ready    <= s_ready_next;
            tx_active  <= tx_active_next;
            frame_done <= fin;
            if (accept) begin
                shift_reg <= s_data;
                sync_idx  <= '0;
                pay_cnt   <= CNT_W'(PAYLOAD_W);
            end else begin
                if (do_sync) begin
                    sync_idx <= sync_idx + 2'd1;
                end
                if (do_pay) begin
                    shift_reg <= shift_reg << 1;
                    pay_cnt   <= pay_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule
